// File: rtl/omsp_bin2bcd.sv
// omsp_bin2bcd
// Sequential binary-to-packed-BCD converter for the openMSP430 datapath.
// Uses double-dabble: on each clock every BCD digit that is >= 5 gets 3
// added, then the whole {bcd_acc, bin_sh} register shifts left by one.
// After BIN_W iterations bcd_acc holds the packed BCD value of the operand.
//
// Handshake (valid/ready style):
//   - i_start is the request. It is accepted only while the FSM is IDLE
//     (o_busy=0), on the rising edge where i_start=1. i_bin_in is captured
//     on that same edge.
//   - While o_busy=1 the request is ignored. Requests are not queued.
//   - o_done pulses for exactly one cycle, in the same cycle that o_bcd_out
//     takes the new result and o_busy drops.
//   - o_bcd_out holds its value until the next conversion completes.
//   - If i_start is held high, a new conversion begins on the edge that
//     ends the done cycle.
// o_dbg_state exposes the FSM state (0=IDLE, 1=CONV) for checkers.
//
// 10^BCD_DIGITS must exceed 2^BIN_W - 1 for the result to fit.

module omsp_bin2bcd #(
  parameter int BIN_W      = 16,
  parameter int BCD_DIGITS = 5
) (
  input  logic                    i_mclk,
  input  logic                    i_reset_n,
  input  logic                    i_start,
  input  logic [BIN_W-1:0]        i_bin_in,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [4*BCD_DIGITS-1:0] o_bcd_out,
  output logic                    o_dbg_state
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int WRK_W = BCD_W + BIN_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  // Registered state
  state_t             r_state;
  logic [BCD_W-1:0]   r_bcd_acc;
  logic [BIN_W-1:0]   r_bin_sh;
  logic [CNT_W-1:0]   r_cnt;
  logic [BCD_W-1:0]   r_bcd_out;
  logic               r_done;

  // Next-state values
  state_t             w_state_nxt;
  logic [BCD_W-1:0]   w_bcd_acc_nxt;
  logic [BIN_W-1:0]   w_bin_sh_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [BCD_W-1:0]   w_bcd_out_nxt;
  logic               w_done_nxt;

  // Datapath intermediates
  logic [BCD_W-1:0]   w_acc_corr;
  logic [WRK_W-1:0]   w_work_shift;
  logic [BCD_W-1:0]   w_acc_shift;
  logic [BIN_W-1:0]   w_bin_shift;
  logic               w_last_iter;

  // Add-3 correction, applied to all digits in parallel. Digits are 4-bit
  // modulo; a corrected digit is at most 12, so no carry leaves a digit.
  always_comb begin
    w_acc_corr = r_bcd_acc;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (r_bcd_acc[4*d +: 4] >= 4'd5) begin
        w_acc_corr[4*d +: 4] = r_bcd_acc[4*d +: 4] + 4'd3;
      end
    end
  end

  // One-bit left shift of the corrected working register, zero into LSB.
  assign w_work_shift = {w_acc_corr, r_bin_sh} << 1;
  assign w_acc_shift  = w_work_shift[WRK_W-1:BIN_W];
  assign w_bin_shift  = w_work_shift[BIN_W-1:0];
  assign w_last_iter  = (r_cnt == CNT_W'(1));

  // Next-state and datapath control for the two-state FSM.
  always_comb begin
    w_state_nxt   = r_state;
    w_bcd_acc_nxt = r_bcd_acc;
    w_bin_sh_nxt  = r_bin_sh;
    w_cnt_nxt     = r_cnt;
    w_bcd_out_nxt = r_bcd_out;
    w_done_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_bin_sh_nxt  = i_bin_in;
          w_bcd_acc_nxt = '0;
          w_cnt_nxt     = CNT_W'(BIN_W);
          w_state_nxt   = ST_CONV;
        end
      end
      ST_CONV: begin
        w_bcd_acc_nxt = w_acc_shift;
        w_bin_sh_nxt  = w_bin_shift;
        w_cnt_nxt     = r_cnt - CNT_W'(1);
        if (w_last_iter) begin
          w_bcd_out_nxt = w_acc_shift;
          w_done_nxt    = 1'b1;
          w_state_nxt   = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and working registers; reset discards any in-flight conversion.
  always_ff @(posedge i_mclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= ST_IDLE;
      r_bcd_acc <= '0;
      r_bin_sh  <= '0;
      r_cnt     <= '0;
      r_bcd_out <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bcd_acc <= w_bcd_acc_nxt;
      r_bin_sh  <= w_bin_sh_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bcd_out <= w_bcd_out_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign o_busy      = (r_state == ST_CONV);
  assign o_done      = r_done;
  assign o_bcd_out   = r_bcd_out;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_omsp_bin2bcd.sv
// Testbench for omsp_bin2bcd: directed vector table, hand-written
// multi-cycle sequences (reset mid-conversion, start while busy,
// back-to-back) and a short random sweep against a divide-by-10 model.

module tb_omsp_bin2bcd;

  localparam int BIN_W = 16;
  localparam int BCD_W = 20;
  localparam int LAT   = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             i_reset_n;
  logic             i_start;
  logic [BIN_W-1:0] i_bin_in;
  logic             o_busy;
  logic             o_done;
  logic [BCD_W-1:0] o_bcd_out;
  logic             o_dbg_state;

  omsp_bin2bcd #(.BIN_W(BIN_W), .BCD_DIGITS(5)) dut (
    .i_mclk      (clk),
    .i_reset_n   (i_reset_n),
    .i_start     (i_start),
    .i_bin_in    (i_bin_in),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_bcd_out   (o_bcd_out),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [BCD_W-1:0] exp_q[$];

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic [BCD_W-1:0] bcd;
  } vec_t;
  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [BCD_W-1:0] ref_bcd(input logic [BIN_W-1:0] b);
    int v;
    logic [BCD_W-1:0] r;
    v = int'(b);
    r = '0;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Wait at negedges until o_done, bounded; cyc counts negedges waited.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (o_done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // ---------------- driver ----------------
  task automatic convert(input logic [BIN_W-1:0] b, input logic [BCD_W-1:0] exp, input string name);
    int cyc;
    logic [BCD_W-1:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    i_start  = 1'b1;
    i_bin_in = b;
    @(negedge clk);
    i_start  = 1'b0;
    i_bin_in = 16'($urandom);
    check({name, "_busy"}, {31'd0, o_busy}, 32'd1);
    wait_done(cyc);
    check({name, "_lat"}, cyc, LAT);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({name, "_bcd"}, o_bcd_out, e);
    check({name, "_busy_at_done"}, {31'd0, o_busy}, 32'd0);
    @(negedge clk);
    check({name, "_done_pulse"}, {31'd0, o_done}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int n_done;
    logic [BIN_W-1:0] b;
    logic [BCD_W-1:0] last_bcd;

    vecs[0]  = '{16'h04D2, 20'h01234};
    vecs[1]  = '{16'h0000, 20'h00000};
    vecs[2]  = '{16'hFFFF, 20'h65535};
    vecs[3]  = '{16'd9,    20'h00009};
    vecs[4]  = '{16'd10,   20'h00010};
    vecs[5]  = '{16'd99,   20'h00099};
    vecs[6]  = '{16'd100,  20'h00100};
    vecs[7]  = '{16'h0BB8, 20'h03000};
    vecs[8]  = '{16'h0457, 20'h01111};
    vecs[9]  = '{16'h270F, 20'h09999};
    vecs[10] = '{16'h0001, 20'h00001};
    vecs[11] = '{16'h8000, 20'h32768};
    vecs[12] = '{16'h2710, 20'h10000};
    vecs[13] = '{16'd50,   20'h00050};

    i_reset_n = 1'b0;
    i_start   = 1'b0;
    i_bin_in  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  {31'd0, o_busy}, 32'd0);
    check("rst_done",  {31'd0, o_done}, 32'd0);
    check("rst_bcd",   o_bcd_out, 32'd0);
    check("rst_state", {31'd0, o_dbg_state}, 32'd0);
    i_reset_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      convert(vecs[i].bin, vecs[i].bcd, $sformatf("vec%0d", i));
    end

    // Reset mid-conversion of 0xFFFF (bcd_out currently 0x00050)
    @(negedge clk);
    i_start  = 1'b1;
    i_bin_in = 16'hFFFF;
    @(negedge clk);
    i_start = 1'b0;
    check("midrst_state_conv", {31'd0, o_dbg_state}, 32'd1);
    repeat (4) @(negedge clk);
    i_reset_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, o_busy}, 32'd0);
    check("midrst_done", {31'd0, o_done}, 32'd0);
    check("midrst_bcd",  o_bcd_out, 32'd0);
    @(negedge clk);
    i_reset_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (o_done === 1'b1) n_done++;
    end
    check("midrst_no_done", n_done, 0);
    check("midrst_idle", {31'd0, o_busy}, 32'd0);

    // Start while busy: second request at cycle 3 must be ignored
    @(negedge clk);
    i_start  = 1'b1;
    i_bin_in = 16'h0BB8;
    @(negedge clk);
    i_start = 1'b0;
    repeat (2) @(negedge clk);
    i_start  = 1'b1;
    i_bin_in = 16'h0001;
    @(negedge clk);
    i_start = 1'b0;
    n_done   = 0;
    last_bcd = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_done === 1'b1) begin
        n_done++;
        last_bcd = o_bcd_out;
      end
    end
    check("busy_start_ndone", n_done, 1);
    check("busy_start_bcd", last_bcd, 32'h03000);
    check("busy_start_busy", {31'd0, o_busy}, 32'd0);

    // Back-to-back with start held high
    exp_q.push_back(20'h01111);
    exp_q.push_back(20'h09999);
    @(negedge clk);
    i_start  = 1'b1;
    i_bin_in = 16'h0457;
    wait_done(cyc);
    check("b2b_lat1", cyc, LAT + 1);
    check("b2b_bcd1", o_bcd_out, exp_q.size() > 0 ? exp_q.pop_front() : '0);
    i_bin_in = 16'h270F;
    @(negedge clk);
    i_start = 1'b0;
    check("b2b_restart_busy", {31'd0, o_busy}, 32'd1);
    cyc = 0;
    while (o_done !== 1'b1 && cyc < 40) begin
      check("b2b_hold", o_bcd_out, 32'h01111);
      @(negedge clk);
      cyc++;
    end
    check("b2b_lat2", cyc, LAT);
    check("b2b_bcd2", o_bcd_out, exp_q.size() > 0 ? exp_q.pop_front() : '0);
    @(negedge clk);

    // Short random sweep against the reference model
    for (int i = 0; i < 200; i++) begin
      b = 16'($urandom_range(0, 65535));
      convert(b, ref_bcd(b), "rand");
      for (int d = 0; d < 5; d++) begin
        check("rand_digit", {31'd0, (o_bcd_out[4*d +: 4] <= 4'd9)}, 32'd1);
      end
    end

    check("exp_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1);
  end

endmodule
